// File: rtl/add32_sched_pkg.sv
// rtl/add32_sched_pkg.sv - shared types and constants for the add32 round-robin scheduler
package add32_sched_pkg;

   localparam int NREQ_DFLT = 4;

   // Lane status bit positions within each 32-bit lane of the status word
   localparam int ST_LS = 0;
   localparam int ST_EQ = 1;
   localparam int ST_GT = 2;

   typedef struct packed {
      logic [127:0] src0;
      logic [127:0] src1;
      logic         sign_s0;
      logic         sign_s1;
      logic         sign_d;
   } add_op_t;

endpackage

// File: rtl/add32_rr_sched_rr_arbiter.sv
// rtl/add32_rr_sched_rr_arbiter.sv - combinational round-robin arbiter searching upward from a pointer
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx
);

   always_comb begin
      int             k;
      logic [IDW-1:0] w_k;
      logic           w_found;
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      k       = 0;
      w_k     = '0;
      // Visit ptr, ptr+1, ... with wrap; the first valid requester wins
      for (int i = 0; i < NREQ; i++) begin
         k = int'(i_ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         w_k = k[IDW-1:0];
         if (!w_found && i_req[w_k]) begin
            w_found    = 1'b1;
            o_gnt[w_k] = 1'b1;
            o_idx      = w_k;
         end
      end
   end

endmodule

// File: rtl/add32_rr_sched.sv
// rtl/add32_rr_sched.sv - shares one 4-lane 32-bit add/compare datapath among NREQ requesters
module add32_rr_sched
   import add32_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DFLT,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*128-1:0] req_src0,
   input  logic [NREQ*128-1:0] req_src1,
   input  logic [NREQ-1:0]   req_sign_s0,
   input  logic [NREQ-1:0]   req_sign_s1,
   input  logic [NREQ-1:0]   req_sign_d,
   output logic [127:0]      dp_src0,
   output logic [127:0]      dp_src1,
   output logic              dp_sign_s0,
   output logic              dp_sign_s1,
   output logic              dp_sign_d,
   input  logic [127:0]      dp_dst,
   input  logic [127:0]      dp_st,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [127:0]      rsp_dst,
   output logic [127:0]      rsp_st,
   output logic [IDW-1:0]    rsp_id,
   output logic [CNTW-1:0]   op_cnt,
   output logic              busy
);

   add_op_t         w_ops [NREQ];
   add_op_t         w_sel_op;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic [IDW-1:0]  w_sel;
   logic [IDW-1:0]  w_ptr_nxt;
   logic            w_any;
   logic            w_slot_free;
   logic            w_can_grant;

   logic [IDW-1:0]  r_ptr;
   logic            r_rsp_valid;
   logic [127:0]    r_rsp_dst;
   logic [127:0]    r_rsp_st;
   logic [IDW-1:0]  r_rsp_id;
   logic [CNTW-1:0] r_op_cnt;

   for (genvar k = 0; k < NREQ; k++) begin : g_ops
      assign w_ops[k] = {req_src0[128*k +: 128], req_src1[128*k +: 128],
                         req_sign_s0[k], req_sign_s1[k], req_sign_d[k]};
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_any       = |req_valid;
   assign w_slot_free = !r_rsp_valid || rsp_ready;
   assign w_can_grant = en && w_slot_free && w_any;
   assign w_ptr_nxt   = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

   // With no request pending the mux parks on the pointer so dp_* never floats
   assign w_sel      = w_any ? w_idx : r_ptr;
   assign w_sel_op   = w_ops[w_sel];
   assign dp_src0    = w_sel_op.src0;
   assign dp_src1    = w_sel_op.src1;
   assign dp_sign_s0 = w_sel_op.sign_s0;
   assign dp_sign_s1 = w_sel_op.sign_s1;
   assign dp_sign_d  = w_sel_op.sign_d;

   assign req_ready = (w_can_grant && rst_n) ? w_gnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_dst   <= '0;
         r_rsp_st    <= '0;
         r_rsp_id    <= '0;
         r_op_cnt    <= '0;
      end else begin
         if (r_rsp_valid && rsp_ready) r_op_cnt <= r_op_cnt + 1'b1;
         if (w_can_grant) begin
            r_rsp_dst   <= dp_dst;
            r_rsp_st    <= dp_st;
            r_rsp_id    <= w_idx;
            r_rsp_valid <= 1'b1;
            r_ptr       <= w_ptr_nxt;
         end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_dst   = r_rsp_dst;
   assign rsp_st    = r_rsp_st;
   assign rsp_id    = r_rsp_id;
   assign op_cnt    = r_op_cnt;
   assign busy      = r_rsp_valid || w_any;

endmodule

// File: doc/add32_rr_sched.md
Name: add32_rr_sched

Overview:
Round-robin scheduler that shares one 4-lane 32-bit add/compare datapath between NREQ requesters. Each requester offers an operand pair plus sign controls over a valid/ready handshake. The scheduler steers the granted operands onto the shared datapath, which is combinational. It registers the datapath result and lane status into a single response stage, tagged with the requester id. It sits between the issue ports of the integer cells and the shared add unit, and drives that unit's input pins directly.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of the requester id tag
CNTW, 32, width of the completed-operation counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; low blocks new grants, the response stage still drains
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_src0  in  NREQ*128  operand A, requester k at [128k +: 128]
req_src1  in  NREQ*128  operand B
req_sign_s0  in  NREQ  operand A signed
req_sign_s1  in  NREQ  operand B signed
req_sign_d  in  NREQ  destination signed
dp_src0  out  128  to shared datapath
dp_src1  out  128  to shared datapath
dp_sign_s0  out  1  to shared datapath
dp_sign_s1  out  1  to shared datapath
dp_sign_d  out  1  to shared datapath
dp_dst  in  128  datapath sum, combinational from dp_* outputs
dp_st  in  128  datapath status; lane j bits [32j+2:32j] = {gt,eq,ls}, other bits 0
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_dst  out  128  registered dp_dst
rsp_st  out  128  registered dp_st
rsp_id  out  IDW  requester index of the response
op_cnt  out  CNTW  count of completed responses (rsp_valid && rsp_ready)
busy  out  1  rsp_valid || |req_valid

Behaviour:
- Reset: rsp_valid=0, rsp_dst=0, rsp_st=0, rsp_id=0, op_cnt=0, priority pointer=0. req_ready is combinationally 0 while rst_n is low.
- Definition: slot_free = !rsp_valid || rsp_ready.
- can_grant = en && slot_free && |req_valid.
- Arbiter: round-robin, searching from pointer ptr upward with wrap. The winner g is the first k with req_valid[k], in the order ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
- req_ready[g] = can_grant; all other bits are 0. Handshake completes on req_valid[g] && req_ready[g].
- Datapath mux: dp_* carry requester g's fields whenever any req_valid is set. Otherwise dp_* carry requester ptr's fields. No X is ever driven.
- On grant: rsp_dst<=dp_dst, rsp_st<=dp_st, rsp_id<=g, rsp_valid<=1, ptr<=(g+1) mod NREQ.
- Latency: the response is valid in the cycle after the grant.
- Throughput: 1 op/cycle while rsp_ready=1.
- Drain without new grant: rsp_valid && rsp_ready with no grant -> rsp_valid<=0.
- Response hold: while rsp_valid && !rsp_ready, rsp_* stay stable, no grant occurs, and all req_ready are 0.
- Simultaneous drain and grant in the same cycle: the new result is loaded and rsp_valid stays 1.
- ptr wraps from NREQ-1 to 0. ptr is unchanged on cycles with no grant.
- op_cnt increments on each rsp handshake and wraps at 2^CNTW.
- en falling: no grant from the next edge. A response already pending still completes.
- Requesters must hold their fields stable while req_valid is high and not yet granted. The scheduler does not latch requests.
- Reset asserted mid-operation: the pending response is discarded and all state returns to reset values.

Decomposition:
- Package add32_sched_pkg holds:
  - typedef add_op_t {src0[127:0], src1[127:0], sign_s0, sign_s1, sign_d}
  - localparams for the status bit positions: ST_LS=0, ST_EQ=1, ST_GT=2
  - default NREQ
- One sub-module, rr_arbiter: NREQ request vector plus pointer in, one-hot grant and encoded index out, purely combinational. The pointer register lives in add32_rr_sched.
- The shared add unit is external; the bench instantiates it, or a behavioural model of it, on the dp_* pins.

Test Plan:
- Single op, unsigned. Requester 0: src0 lane0=5, src1 lane0=3, signs=0, rsp_ready=1. Required: rsp_valid one cycle after grant, rsp_id=0, rsp_st[2:0]=3'b100, op_cnt=1.
- Sign handling, requester 2. src0 lane1=0xFFFFFFFF, src1 lane1=1, sign_s0=1. Required: rsp_st[34:32]=3'b001. Repeated with signs=0, required: 3'b100.
- Fairness. All 4 requesters valid continuously, rsp_ready=1. Required: grant order 0,1,2,3,0,1..., one response per cycle, op_cnt=8 after 8 completions.
- Backpressure. rsp_ready=0 for 5 cycles with requesters 1 and 3 valid. Required: rsp_* stable, req_ready=0. On release: back-to-back grants to 1 then 3, with drain and load in the same cycle.
- Enable. Drop en while a response is pending. Required: the pending response completes and no further req_ready asserts until en=1. The pointer is preserved, so the next grant follows the last winner.
- Reset mid-operation. Assert rst_n=0 with rsp_valid=1. Required: rsp_valid, op_cnt and ptr cleared immediately (asynchronously). After release, the first grant goes to the lowest valid index starting from 0.
